cla_serial_word_adder: RTL

Multi-cycle word adder controller. It sequences one instance of the team's 4-bit carry-look-ahead adder (`carry_look_ahead_adder_4_bit`) nibble-by-nibble to add two WIDTH-bit operands, chaining the carry through a register between cycles. It sits between a valid/ready producer and a valid/ready consumer wherever a wide add is needed and area matters more than throughput.

---
 rtl/cla_serial_word_adder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cla_serial_word_adder.sv
// Serial word adder: one 4-bit CLA stepped nibble-by-nibble with a carry register.
// Define CLA_SUB_EN to add the sub port (a - b - c_in with borrow-out).

module carry_look_ahead_adder_4_bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_s = w_p ^ w_c[3:0];
    assign o_c = w_c[4];
endmodule

module cla_serial_word_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;

    logic             w_sub;
    logic             w_sub_r;
    logic [WIDTH-1:0] w_b_in;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_s;
    logic             w_co;

`ifdef CLA_SUB_EN
    logic r_sub;

    assign w_sub   = sub;
    assign w_sub_r = r_sub;
    assign w_b_in  = b ^ {WIDTH{sub}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_sub <= sub;
        end
    end
`else
    assign w_sub   = 1'b0;
    assign w_sub_r = 1'b0;
    assign w_b_in  = b;
`endif

    assign w_a_nib = r_a[4*r_idx +: 4];
    assign w_b_nib = r_b[4*r_idx +: 4];

    carry_look_ahead_adder_4_bit u_cla (
        .i_a (w_a_nib),
        .i_b (w_b_nib),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= c_in ^ w_sub;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= w_s;
                    r_carry             <= w_co;
                    r_idx               <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        // borrow is the inverted carry when subtracting
                        r_c_out <= w_co ^ w_sub_r;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign c_out     = r_c_out;
endmodule
